// File: rtl/transmisor_dac_spi_pkg.sv
// Shared types and constants for the filter-to-DAC serial transmitter.
package transmisor_dac_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int DAC_BITS   = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // DAC121S101 word: two don't-care bits, power-down mode, 12-bit code.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] pd,
                                                        input logic [DAC_BITS-1:0] code);
    return {2'b00, pd, code};
  endfunction

endpackage

// File: rtl/transmisor_dac_spi_sclk_tick_gen.sv
// Half-period tick generator for SCLK: one tick every DIV enabled cycles.
module transmisor_dac_spi_sclk_tick_gen #(
  parameter int DIV = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/transmisor_dac_spi.sv
// Takes signed filter samples, converts them to 12-bit offset binary and
// shifts them out MSB-first as 16-bit SYNC-framed words to a serial DAC.
module transmisor_dac_spi
  import transmisor_dac_spi_pkg::*;
#(
  parameter int         N       = 25,
  parameter int         DIV     = 2,
  parameter logic [1:0] PD_MODE = PD_NORMAL
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [N-1:0] Yk,
  input  logic         Bandera_Listo,
  output logic         SCLK,
  output logic         SYNC_n,
  output logic         DIN,
  output logic         Ocupado,
  output logic         Bandera_Enviado,
  output logic         Sobrecarga
);

  state_t                  state_q, state_d;
  logic                    listo_q, listo_d;
  logic                    pending_q, pending_d;
  logic [DAC_BITS-1:0]     hold_q, hold_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic                    gap_half_q, gap_half_d;
  logic                    sclk_q, sclk_d;
  logic                    sync_n_q, sync_n_d;
  logic                    din_q, din_d;
  logic                    ocupado_q, ocupado_d;
  logic                    enviado_q, enviado_d;
  logic                    sobre_q, sobre_d;

  logic                    new_sample;
  logic                    tick;
  logic [DAC_BITS-1:0]     code;
  logic [FRAME_BITS-1:0]   frame_word;
  logic                    yk_lsbs_unused;

  assign new_sample = Bandera_Listo && !listo_q;
  // Inverting the sign bit maps two's complement onto offset binary.
  assign code       = {~Yk[N-1], Yk[N-2:N-DAC_BITS]};
  assign frame_word = build_frame(PD_MODE, hold_q);
  assign yk_lsbs_unused = ^Yk[N-DAC_BITS-1:0];

  transmisor_dac_spi_sclk_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .en      ((state_q == ST_SHIFT) || (state_q == ST_GAP)),
    .clr     (state_q == ST_LOAD),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    listo_d    = Bandera_Listo;
    pending_d  = pending_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    gap_half_d = gap_half_q;
    sclk_d     = sclk_q;
    sync_n_d   = sync_n_q;
    din_d      = din_q;
    enviado_d  = 1'b0;
    sobre_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (new_sample) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d   = frame_word;
        din_d     = frame_word[FRAME_BITS-1];
        sync_n_d  = 1'b0;
        sclk_d    = 1'b1;
        pending_d = 1'b0;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else begin
            // Rising SCLK: DAC has already sampled DIN, so advance the bit.
            sclk_d = 1'b1;
            if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
              state_d    = ST_GAP;
              sync_n_d   = 1'b1;
              din_d      = 1'b0;
              enviado_d  = 1'b1;
              gap_half_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
              din_d     = shift_q[FRAME_BITS-2];
            end
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_half_q) begin
            gap_half_d = 1'b0;
            state_d    = (pending_q || new_sample) ? ST_LOAD : ST_IDLE;
          end else begin
            gap_half_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A sample arriving in LOAD is not an overrun: the held one is being consumed now.
    if (new_sample) begin
      hold_d = code;
      if (state_q != ST_IDLE) begin
        if (pending_q && (state_q != ST_LOAD)) sobre_d = 1'b1;
        pending_d = 1'b1;
      end
    end

    ocupado_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      listo_q    <= 1'b0;
      pending_q  <= 1'b0;
      hold_q     <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      gap_half_q <= 1'b0;
      sclk_q     <= 1'b1;
      sync_n_q   <= 1'b1;
      din_q      <= 1'b0;
      ocupado_q  <= 1'b0;
      enviado_q  <= 1'b0;
      sobre_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      listo_q    <= listo_d;
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_half_q <= gap_half_d;
      sclk_q     <= sclk_d;
      sync_n_q   <= sync_n_d;
      din_q      <= din_d;
      ocupado_q  <= ocupado_d;
      enviado_q  <= enviado_d;
      sobre_q    <= sobre_d;
    end
  end

  assign SCLK            = sclk_q;
  assign SYNC_n          = sync_n_q;
  assign DIN             = din_q;
  assign Ocupado         = ocupado_q;
  assign Bandera_Enviado = enviado_q;
  assign Sobrecarga      = sobre_q;

endmodule
